// File: rtl/register_file_ext.sv
// register_file_ext: parametrised multi-read-port register file with an
// optional hard-wired zero entry, optional write-first bypass and a
// sequential clear engine that zeroes the array after reset or on request.
module register_file_ext #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [NRD*ADDR_W-1:0] i_ra,
  output logic [NRD*WIDTH-1:0]  o_rd,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_wa,
  input  logic [WIDTH-1:0]      i_wd,
  input  logic                  i_clr,
  output logic                  o_busy,
  output logic                  o_wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_wr_drop;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic w_busy;
  logic w_wr_zero;
  logic w_wr_ok;

  assign w_busy    = (r_state == S_CLEAR);
  // Writes to entry 0 vanish silently when it is the hard-wired zero register
  assign w_wr_zero = (ZERO_REG != 0) && (i_wa == '0);
  assign w_wr_ok   = i_we && !w_busy && !w_wr_zero;

  assign o_busy    = w_busy;
  assign o_wr_drop = r_wr_drop;

  // Clear engine: walks ptr across the array, returns to IDLE after the last entry
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= S_CLEAR;
      r_ptr     <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wr_drop <= 1'b0;
          if (i_clr) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
          end
        end
        default: begin
          // Any write attempted while clearing is discarded and flagged once
          r_wr_drop <= i_we;
          if (r_ptr == {ADDR_W{1'b1}}) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
      endcase
    end
  end

  // Storage update: clear engine owns the write port while busy
  always_ff @(posedge i_clk) begin
    if (w_busy) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_ok) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [WIDTH-1:0]  w_rd;

      assign w_ra = i_ra[gi*ADDR_W +: ADDR_W];

      // Per-port read mux: busy blanking, zero entry, write-first forward, array
      always_comb begin
        w_rd = r_mem[w_ra];
        if (w_busy) begin
          w_rd = '0;
        end else if ((ZERO_REG != 0) && (w_ra == '0)) begin
          w_rd = '0;
        end else if ((BYPASS != 0) && w_wr_ok && (i_wa == w_ra)) begin
          w_rd = i_wd;
        end
      end

      assign o_rd[gi*WIDTH +: WIDTH] = w_rd;
    end
  endgenerate

endmodule

// File: doc/register_file_ext.md
Name: register_file_ext

Overview:
- Parametrised successor to the 32-entry three-port register file.
- Configurable width, depth and read-port count, with an optional hard-wired zero register and optional write-to-read bypass.
- Built-in sequential clear engine zeroes the array after reset or on request; no per-entry reset flops are needed.
- Sits in the CPU datapath as the architectural GPR file; also reused as a scratch file by the debug unit.

Parameters:
WIDTH, 32, data width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NRD, 2, number of asynchronous read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports (write-first)

Ports:
clk  input  1  clock, rising edge active
rstn  input  1  asynchronous reset, active low
ra  input  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd  output  NRD*WIDTH  read data; port k uses bits [k*WIDTH +: WIDTH]
we  input  1  write enable, active high
wa  input  ADDR_W  write address
wd  input  WIDTH  write data
clr  input  1  single-cycle pulse requesting a full array clear
busy  output  1  high while the clear engine runs
wr_drop  output  1  registered one-cycle pulse: a write was discarded

Behaviour:
- Storage: DEPTH x WIDTH array, no reset on array bits.
- Clear FSM states: IDLE and CLEAR. It also has a pointer ptr of ADDR_W bits.
- Reset: rstn low asynchronously forces state=CLEAR, ptr=0 and wr_drop=0. busy is a combinational decode of state, so it reads 1.
- rd shows 0 while busy=1.
- CLEAR state: each rising edge writes mem[ptr]<=0 and increments ptr.
  - When ptr==DEPTH-1, that edge also moves the FSM to IDLE.
  - busy is therefore high for exactly DEPTH cycles after rstn rises.
- IDLE with clr=1: at the next edge state=CLEAR and ptr=0. busy rises in the following cycle.
- clr while in CLEAR: ignored; there is no restart.
- Reset asserted mid-clear: the clear restarts from ptr=0.
- Writes in IDLE: on an edge with we=1, mem[wa]<=wd. The exception is ZERO_REG=1 with wa==0, where the write is silently ignored and wr_drop stays 0.
- Writes in CLEAR: we=1 is discarded. wr_drop=1 in the next cycle, and only for one cycle per discarded write.
- Same-edge clr and we in IDLE: the write completes; the clear starts next cycle.
- Reads (combinational, per port k):
  - busy=1 -> rd_k = 0.
  - ZERO_REG=1 and ra_k==0 -> 0.
  - BYPASS=1, we=1, wa==ra_k and the write is not suppressed -> rd_k = wd.
  - Otherwise rd_k = mem[ra_k].
- Bypass never forwards during busy, nor for wa==0 when ZERO_REG=1.
- Multiple read ports may share an address; each port is independent.
- Latency: write-to-read is 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
- ptr wraps only via the FSM exit; it never exceeds DEPTH-1.

Test Plan:
1. Reset release: rstn low for 3 cycles, then high. Required: busy=1 for exactly 32 cycles, then 0. Afterwards every address on every rd port reads 32'h0. Bench also pre-fills garbage via a model-forced write before reset and checks it is cleared.
2. Write/read: write 32'hDEADBEEF to x5 and 32'h12345678 to x31, then read ra0=5, ra1=31. Required: both values returned. With BYPASS=1, rd0=32'hDEADBEEF is visible in the same cycle as the write.
3. Zero register: we=1, wa=0, wd=32'hFFFFFFFF, then read ra0=0. Required: rd0=0, wr_drop=0, no bypass of FFFFFFFF.
4. clr mid-operation: write x7=32'hA5A5A5A5, pulse clr, then write x9=32'h1 during busy. Required: wr_drop pulses once, busy lasts 32 cycles, and x7 and x9 both read 0 afterwards.
5. Reset mid-clear: pulse clr, assert rstn low at busy cycle 10. Required: busy stays high for 32 full cycles after rstn rises.
6. Parameter sweep: WIDTH=16, ADDR_W=3, NRD=4, ZERO_REG=0. Required: entry 0 is writable (16'hBEEF read back), busy lasts 8 cycles, and all 4 ports read independent addresses correctly.
